// File: rtl/risc_issue_sequencer.sv
// ---------------------------------------------------------------------------
// risc_issue_sequencer
//
// Issue controller placed in front of the simple RISC ALU datapath.
// Instruction word: opcode[15:12], op1[11:6], op2[5:0]
// (NOP=0, ADD=1, SUB=2, MUL=3, DIV=4, 5..15 illegal).
//
// Incoming instructions are queued in a small FIFO. They are issued one at a
// time on alu_instr, and each is held for an opcode-dependent number of
// cycles. The datapath result is then captured and offered on a valid/ready
// result port. Divide-by-zero and illegal opcodes are reported through
// res_err with res_data = 16'hFFFF.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   in_valid     instruction offered
//   in_instr     instruction word
//   in_ready     FIFO can accept (fifo_count < FIFO_DEPTH)
//   alu_instr    registered instruction driven to the datapath
//   alu_result   datapath result
//   res_valid    result available (DONE state)
//   res_data     captured result
//   res_opcode   opcode of the presented result
//   res_err      DIV by zero or illegal opcode
//   res_ready    consumer accepts result
//   busy         sequencer active or FIFO non-empty
//   retired_cnt  results handed off (wraps)
//   fifo_count   FIFO occupancy
// ---------------------------------------------------------------------------
module risc_issue_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDSUB_LAT = 2,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [15:0]                   in_instr,
  output logic                          in_ready,
  output logic [15:0]                   alu_instr,
  input  logic [15:0]                   alu_result,
  output logic                          res_valid,
  output logic [15:0]                   res_data,
  output logic [3:0]                    res_opcode,
  output logic                          res_err,
  input  logic                          res_ready,
  output logic                          busy,
  output logic [15:0]                   retired_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int MAX_LAT = (ADDSUB_LAT > MUL_LAT) ?
                           ((ADDSUB_LAT > DIV_LAT) ? ADDSUB_LAT : DIV_LAT) :
                           ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_DIV = 4'd4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // The counter is loaded with LAT-1, so EXEC lasts exactly LAT cycles.
  function automatic logic [LAT_W-1:0] lat_load(input logic [3:0] op);
    case (op)
      4'd3:    return LAT_W'(MUL_LAT - 1);
      4'd4:    return LAT_W'(DIV_LAT - 1);
      default: return LAT_W'(ADDSUB_LAT - 1);
    endcase
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      head;
  logic [3:0]       head_op;
  logic             push, pop;
  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

  assign head     = mem[rd_ptr];
  assign head_op  = head[15:12];
  assign in_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  // The head is consumed only when the sequencer can take it:
  // from IDLE, or from DONE as the current result is handed off.
  assign pop      = (count != '0) &&
                    ((state == IDLE) || ((state == DONE) && res_ready));

  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);

  // NOTE: storage array has no reset; the pointers and count alone define
  // which entries are valid, so clearing the data would add nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking ones would make the result depend
  // on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      alu_instr   <= '0;
      lat_cnt     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_opcode  <= '0;
      res_err     <= 1'b0;
      retired_cnt <= '0;
    end else if (pop) begin
      // A pop from DONE always coincides with the result handshake.
      if (state == DONE) retired_cnt <= retired_cnt + 16'd1;
      if (head_op == OP_NOP) begin
        state     <= IDLE;
        alu_instr <= '0;
        res_valid <= 1'b0;
      end else if (head_op <= OP_DIV) begin
        state     <= EXEC;
        alu_instr <= head;
        lat_cnt   <= lat_load(head_op);
        res_valid <= 1'b0;
      end else begin
        // Illegal opcode: never reaches the datapath; report it directly.
        state      <= DONE;
        res_valid  <= 1'b1;
        res_data   <= 16'hFFFF;
        res_opcode <= head_op;
        res_err    <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: ;
        EXEC: begin
          if (lat_cnt == '0) begin
            state      <= DONE;
            res_valid  <= 1'b1;
            res_opcode <= alu_instr[15:12];
            if ((alu_instr[15:12] == OP_DIV) && (alu_instr[5:0] == 6'd0)) begin
              res_data <= 16'hFFFF;
              res_err  <= 1'b1;
            end else begin
              res_data <= alu_result;
              res_err  <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          // FIFO is empty here, otherwise pop would have been taken.
          if (res_ready) begin
            retired_cnt <= retired_cnt + 16'd1;
            state       <= IDLE;
            alu_instr   <= '0;
            res_valid   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
